// File: rtl/wb_sram_ctrl_if.sv
// Wishbone-classic slave bundle for wb_sram_ctrl. The signal names match the
// flat ports of the original controller.
interface wb_sram_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_sram_ctrl.sv
// Wishbone slave on SRAM port 0 plus a streaming reader on port 1 that feeds a
// valid/ready FIFO. Every SRAM input comes straight from a flop.
module wb_sram_ctrl #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    wb_sram_ctrl_if.slave         wb,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [3:0]            sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [31:0]           sram_din0,
    input  logic [31:0]           sram_dout0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [31:0]           sram_dout1,
    input  logic                  strm_start,
    input  logic [ADDR_WIDTH-1:0] strm_addr,
    input  logic [ADDR_WIDTH:0]   strm_len,
    output logic                  strm_valid,
    input  logic                  strm_ready,
    output logic [31:0]           strm_data,
    output logic                  strm_last,
    output logic                  strm_busy
);
    localparam int unsigned RAM_DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [32:0] WIN_LO    = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI    = WIN_LO + 33'(4 * RAM_DEPTH);

    typedef enum logic [2:0] {
        WB_IDLE, WB_WR_HOLD, WB_WR_ACK, WB_RD_WAIT1, WB_RD_CAP
    } wb_state_t;

    typedef enum logic [1:0] {
        ST_IDLE, ST_RUN, ST_DRAIN
    } st_state_t;

    wb_state_t             wb_state_q, wb_state_d;
    logic                  csb0_q, csb0_d;
    logic                  web0_q, web0_d;
    logic [3:0]            wmask0_q, wmask0_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [31:0]           din0_q, din0_d;
    logic                  ack_q, ack_d;
    logic [31:0]           dat_q, dat_d;

    st_state_t             st_state_q, st_state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic                  csb1_q, csb1_d;
    logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
    logic                  iss_last_q, iss_last_d;
    logic                  p1_vld_q, p1_vld_d;
    logic                  p1_last_q, p1_last_d;

    logic [32:0]           fifo_mem_q [FIFO_DEPTH];
    logic [32:0]           fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;

    logic [ADDR_WIDTH-1:0] wb_word;
    logic                  wb_in_win;
    logic                  wb_req;
    logic                  wb_collide;
    logic [PTR_W+1:0]      occ;
    logic                  issue;
    logic                  push;
    logic                  pop;

    always_comb begin
        wb_word   = wb.wbs_adr_i[ADDR_WIDTH+1:2];
        wb_in_win = ({1'b0, wb.wbs_adr_i} >= WIN_LO) && ({1'b0, wb.wbs_adr_i} < WIN_HI);
        // ack_q blocks the still-asserted strobe of the cycle just acknowledged
        wb_req    = wb.wbs_cyc_i && wb.wbs_stb_i && wb_in_win && !ack_q;
        // data in flight is counted so a returning read always has a FIFO slot
        occ       = (PTR_W+2)'(count_q) + (PTR_W+2)'(!csb1_q) + (PTR_W+2)'(p1_vld_q);
        issue     = (st_state_q == ST_RUN) && (remaining_q != '0) &&
                    (occ < (PTR_W+2)'(FIFO_DEPTH));
        wb_collide = wb_req && wb.wbs_we_i && issue && (rd_addr_q == wb_word);
        push      = p1_vld_q;
        pop       = strm_valid && strm_ready;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_state_q  <= WB_IDLE;
            csb0_q      <= 1'b1;
            web0_q      <= 1'b1;
            wmask0_q    <= '0;
            addr0_q     <= '0;
            din0_q      <= '0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            st_state_q  <= ST_IDLE;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            csb1_q      <= 1'b1;
            addr1_q     <= '0;
            iss_last_q  <= 1'b0;
            p1_vld_q    <= 1'b0;
            p1_last_q   <= 1'b0;
            fifo_mem_q  <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            wb_state_q  <= wb_state_d;
            csb0_q      <= csb0_d;
            web0_q      <= web0_d;
            wmask0_q    <= wmask0_d;
            addr0_q     <= addr0_d;
            din0_q      <= din0_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            st_state_q  <= st_state_d;
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            csb1_q      <= csb1_d;
            addr1_q     <= addr1_d;
            iss_last_q  <= iss_last_d;
            p1_vld_q    <= p1_vld_d;
            p1_last_q   <= p1_last_d;
            fifo_mem_q  <= fifo_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        wb_state_d = wb_state_q;
        unique case (wb_state_q)
            WB_IDLE: begin
                if (wb_req) begin
                    if (!wb.wbs_we_i)    wb_state_d = WB_RD_WAIT1;
                    else if (wb_collide) wb_state_d = WB_WR_HOLD;
                    else                 wb_state_d = WB_WR_ACK;
                end
            end
            WB_WR_HOLD:  wb_state_d = WB_WR_ACK;
            WB_WR_ACK:   wb_state_d = WB_IDLE;
            WB_RD_WAIT1: wb_state_d = WB_RD_CAP;
            WB_RD_CAP:   wb_state_d = WB_IDLE;
            default:     wb_state_d = WB_IDLE;
        endcase
    end

    always_comb begin
        csb0_d   = 1'b1;
        web0_d   = 1'b1;
        wmask0_d = wmask0_q;
        addr0_d  = addr0_q;
        din0_d   = din0_q;
        ack_d    = 1'b0;
        dat_d    = dat_q;
        unique case (wb_state_q)
            WB_IDLE: begin
                if (wb_req) begin
                    addr0_d  = wb_word;
                    wmask0_d = wb.wbs_sel_i;
                    din0_d   = wb.wbs_dat_i;
                    if (!wb.wbs_we_i) begin
                        csb0_d = 1'b0;
                    end else if (!wb_collide) begin
                        csb0_d = 1'b0;
                        web0_d = 1'b0;
                    end
                end
            end
            WB_WR_HOLD: begin
                csb0_d = 1'b0;
                web0_d = 1'b0;
            end
            WB_WR_ACK: ack_d = 1'b1;
            WB_RD_CAP: begin
                ack_d = 1'b1;
                dat_d = sram_dout0;
            end
            default: ;
        endcase
    end

    always_comb begin
        st_state_d  = st_state_q;
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        unique case (st_state_q)
            ST_IDLE: begin
                if (strm_start && (strm_len != '0)) begin
                    st_state_d  = ST_RUN;
                    rd_addr_d   = strm_addr;
                    remaining_d = strm_len;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    rd_addr_d   = rd_addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
                    if (remaining_q == (ADDR_WIDTH+1)'(1)) st_state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && strm_last) st_state_d = ST_IDLE;
            end
            default: st_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        csb1_d     = !issue;
        addr1_d    = issue ? rd_addr_q : addr1_q;
        iss_last_d = issue && (remaining_q == (ADDR_WIDTH+1)'(1));
        p1_vld_d   = !csb1_q;
        p1_last_d  = iss_last_q;
        fifo_mem_d = fifo_mem_q;
        if (push) fifo_mem_d[wr_ptr_q] = {p1_last_q, sram_dout1};
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end

    assign sram_csb0     = csb0_q;
    assign sram_web0     = web0_q;
    assign sram_wmask0   = wmask0_q;
    assign sram_addr0    = addr0_q;
    assign sram_din0     = din0_q;
    assign sram_csb1     = csb1_q;
    assign sram_addr1    = addr1_q;
    assign wb.wbs_ack_o  = ack_q;
    assign wb.wbs_dat_o  = dat_q;
    assign strm_valid    = (count_q != '0);
    assign strm_data     = fifo_mem_q[rd_ptr_q][31:0];
    assign strm_last     = strm_valid && fifo_mem_q[rd_ptr_q][32];
    assign strm_busy     = (st_state_q != ST_IDLE);
endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Bench for wb_sram_ctrl: behavioural 1rw1r SRAM, table-driven Wishbone vectors,
// and directed stream/collision sequences.
module tb_wb_sram_ctrl;
    localparam int unsigned AW   = 11;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int unsigned FD   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_sram_ctrl_if wb ();

    logic          sram_csb0, sram_web0, sram_csb1;
    logic [3:0]    sram_wmask0;
    logic [AW-1:0] sram_addr0, sram_addr1;
    logic [31:0]   sram_din0, sram_dout0, sram_dout1;
    logic          strm_start, strm_valid, strm_ready, strm_last, strm_busy;
    logic [AW-1:0] strm_addr;
    logic [AW:0]   strm_len;
    logic [31:0]   strm_data;

    wb_sram_ctrl #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .FIFO_DEPTH(FD)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wb          (wb),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0),
        .sram_csb1   (sram_csb1),
        .sram_addr1  (sram_addr1),
        .sram_dout1  (sram_dout1),
        .strm_start  (strm_start),
        .strm_addr   (strm_addr),
        .strm_len    (strm_len),
        .strm_valid  (strm_valid),
        .strm_ready  (strm_ready),
        .strm_data   (strm_data),
        .strm_last   (strm_last),
        .strm_busy   (strm_busy)
    );

    // SRAM model: inputs sampled at the edge, dout updated for the next edge
    logic [31:0] mem [0:2**AW-1];
    initial for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (!sram_csb0 && !sram_web0) begin
            for (int b = 0; b < 4; b++)
                if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
        end
        if (!sram_csb0 && sram_web0) sram_dout0 <= mem[sram_addr0];
        if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] s_data [$];
    logic        s_last [$];
    logic        s_busy [$];
    int          s_cyc  [$];
    int          issued = 0, accepted = 0, max_out = 0, hold_err = 0;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_word = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (!sram_csb1) issued++;
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (prev_stall && (!strm_valid || {strm_last, strm_data} !== prev_word)) hold_err++;
            prev_stall = strm_valid && !strm_ready;
            prev_word  = {strm_last, strm_data};
            if (strm_valid && strm_ready) begin
                s_data.push_back(strm_data);
                s_last.push_back(strm_last);
                s_busy.push_back(strm_busy);
                s_cyc.push_back(cyc);
                accepted++;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, output logic got_ack, output int lat,
                           output int csb_lo, output logic [31:0] rdat,
                           output logic [AW-1:0] waddr, output logic ack2);
        got_ack = 1'b0; lat = 0; csb_lo = 0; rdat = '0; waddr = '0;
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
        wb.wbs_sel_i = sel;  wb.wbs_adr_i = adr;  wb.wbs_dat_i = dat;
        while (!got_ack && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (!sram_csb0) begin csb_lo++; waddr = sram_addr0; end
            if (wb.wbs_ack_o) begin got_ack = 1'b1; rdat = wb.wbs_dat_o; end
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        @(posedge clk); #1;
        if (!sram_csb0) csb_lo++;
        ack2 = wb.wbs_ack_o;
    endtask

    task automatic wb_write(input logic [AW-1:0] w, input logic [31:0] d);
        logic ga, a2; int l, c; logic [31:0] r; logic [AW-1:0] wa;
        wb_xfer(1'b1, BASE + {19'd0, w, 2'b00}, 4'hF, d, ga, l, c, r, wa, a2);
    endtask

    task automatic wb_read(input logic [AW-1:0] w, output logic [31:0] r);
        logic ga, a2; int l, c; logic [AW-1:0] wa;
        wb_xfer(1'b0, BASE + {19'd0, w, 2'b00}, 4'hF, '0, ga, l, c, r, wa, a2);
    endtask

    task automatic wait_words(input int target, input int budget);
        int n = 0;
        while (s_data.size() < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input string tag, input int base, input logic [31:0] exp[$]);
        check({tag, "_count"}, s_data.size() - base, exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < s_data.size()) begin
                check($sformatf("%s_data%0d", tag, i), s_data[base+i], exp[i]);
                check($sformatf("%s_last%0d", tag, i), s_last[base+i], i == exp.size() - 1);
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic        exp_ack;
        int          exp_lat;
        logic [31:0] exp_rdat;
    } vec_t;

    initial begin
        vec_t          vecs [10];
        logic          ga, a2;
        int            lat, clo, base, iss0, lowcnt;
        logic [31:0]   rd;
        logic [AW-1:0] wa;
        logic [31:0]   exp_q [$];

        vecs[0] = '{1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, 1'b1, 2, 32'h0};
        vecs[1] = '{1'b0, 32'h3000_0010, 4'hF, 32'h0,         1'b1, 3, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h3000_0010, 4'h2, 32'h0000_AA00, 1'b1, 2, 32'h0};
        vecs[3] = '{1'b0, 32'h3000_0010, 4'hF, 32'h0,         1'b1, 3, 32'hDEAD_AAEF};
        vecs[4] = '{1'b1, 32'h3000_1FFC, 4'hF, 32'h1111_2222, 1'b1, 2, 32'h0};
        vecs[5] = '{1'b1, 32'h2FFF_FFFC, 4'hF, 32'hBAD0_BAD0, 1'b0, 0, 32'h0};
        vecs[6] = '{1'b0, 32'h3000_2000, 4'hF, 32'h0,         1'b0, 0, 32'h0};
        vecs[7] = '{1'b0, 32'h3000_1FFC, 4'hF, 32'h0,         1'b1, 3, 32'h1111_2222};
        vecs[8] = '{1'b1, 32'h3000_0000, 4'h9, 32'hC3FF_FFC3, 1'b1, 2, 32'h0};
        vecs[9] = '{1'b0, 32'h3000_0000, 4'hF, 32'h0,         1'b1, 3, 32'hC300_00C3};

        rst = 1'b1;
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = '0;   wb.wbs_adr_i = '0;   wb.wbs_dat_i = '0;
        strm_start = 1'b0; strm_addr = '0; strm_len = '0; strm_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl", {sram_csb0, sram_web0, sram_csb1, wb.wbs_ack_o, strm_valid,
                          strm_last, strm_busy, sram_wmask0}, 11'b111_0000_0000);
        check("rst_bus", {sram_addr0, sram_addr1, sram_din0}, '0);
        check("rst_dat_o", wb.wbs_dat_o, 32'h0);
        rst = 1'b0;
        lowcnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!sram_csb0 || !sram_csb1) lowcnt++;
        end
        check("idle_csb_low_cycles", lowcnt, 0);

        for (int i = 0; i < 10; i++) begin
            wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].wdat, ga, lat, clo, rd, wa, a2);
            check($sformatf("v%0d_ack", i), ga, vecs[i].exp_ack);
            check($sformatf("v%0d_ack_single", i), a2, 1'b0);
            if (vecs[i].exp_ack) begin
                check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
                check($sformatf("v%0d_csb0_cycles", i), clo, 1);
                check($sformatf("v%0d_addr0", i), wa, vecs[i].adr[AW+1:2]);
                if (!vecs[i].we) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdat);
            end else begin
                check($sformatf("v%0d_csb0_cycles", i), clo, 0);
            end
        end

        // wrap-around stream at the top of memory
        wb_write(11'd2046, 32'hA000_07FE);
        wb_write(11'd2047, 32'hA000_07FF);
        wb_write(11'd0,    32'hA000_0000);
        wb_write(11'd1,    32'hA000_0001);
        base = s_data.size();
        strm_ready = 1'b1; strm_addr = 11'd2046; strm_len = 12'd4; strm_start = 1'b1;
        @(posedge clk); #1;
        strm_start = 1'b0;
        check("s1_busy_after_start", strm_busy, 1'b1);
        wait_words(base + 4, 40);
        exp_q = '{32'hA000_07FE, 32'hA000_07FF, 32'hA000_0000, 32'hA000_0001};
        check_stream("s1", base, exp_q);
        if (s_data.size() >= base + 4) begin
            check("s1_consecutive", s_cyc[base+3] - s_cyc[base], 3);
            check("s1_busy_on_last", s_busy[base+3], 1'b1);
        end
        check("s1_busy_end", strm_busy, 1'b0);

        iss0 = issued;
        strm_addr = 11'd7; strm_len = '0; strm_start = 1'b1;
        @(posedge clk); #1;
        strm_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("len0_busy", strm_busy, 1'b0);
        check("len0_reads", issued - iss0, 0);

        // random backpressure
        for (int w = 0; w < 16; w++) wb_write(AW'(100 + w), 32'h5A00_0000 + w);
        base = s_data.size();
        iss0 = issued;
        strm_addr = 11'd100; strm_len = 12'd16; strm_start = 1'b1;
        @(posedge clk); #1;
        strm_start = 1'b0;
        for (int n = 0; n < 400 && s_data.size() < base + 16; n++) begin
            strm_ready = ($urandom_range(0, 1) == 1);
            @(posedge clk); #1;
        end
        strm_ready = 1'b1;
        wait_words(base + 16, 20);
        exp_q = {};
        for (int w = 0; w < 16; w++) exp_q.push_back(32'h5A00_0000 + w);
        check_stream("s2", base, exp_q);
        check("s2_reads_issued", issued - iss0, 16);
        check("s2_max_outstanding_ok", max_out <= FD, 1'b1);
        check("s2_hold_stable_errs", hold_err, 0);
        check("s2_busy_end", strm_busy, 1'b0);

        // write to word 5 in the cycle the streamer issues its read of word 5
        for (int w = 3; w < 7; w++) wb_write(AW'(w), 32'hC0DE_0000 + w);
        base = s_data.size();
        strm_addr = 11'd3; strm_len = 12'd4; strm_start = 1'b1;
        @(posedge clk); #1;
        strm_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        wb_xfer(1'b1, BASE + 32'h14, 4'hF, 32'h7777_8888, ga, lat, clo, rd, wa, a2);
        check("col_ack", ga, 1'b1);
        check("col_lat", lat, 3);
        check("col_csb0_cycles", clo, 1);
        check("col_addr0", wa, 11'd5);
        wait_words(base + 4, 40);
        exp_q = '{32'hC0DE_0003, 32'hC0DE_0004, 32'hC0DE_0005, 32'hC0DE_0006};
        check_stream("col", base, exp_q);
        wb_read(11'd5, rd);
        check("col_readback", rd, 32'h7777_8888);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
